// File: rtl/mini_fetch_unit.sv
// Instruction fetch front end: credit-limited request/grant issue, in-order responses
// into a prefetch FIFO, redirect flush with stale-response drop. Option: MINI_FETCH_HALT_EN.
module mini_fetch_unit #(
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_ir,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  logic              run_q, run_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]     aw_q, aw_d, ar_q, ar_d;
  fetch_ent_t        shown_q, shown_d;

  fetch_ent_t        fifo_q [DEPTH];
  logic [ADDR_W-1:0] aq_q   [DEPTH];

  logic       credit_ok, halt_blk, acc, rsp, dropping, push, pop;
  fetch_ent_t head, push_ent;

  // fifo entries plus in-flight requests never exceed DEPTH, so the sum fits
  assign credit_ok = ({1'b0, cnt_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
  assign imem_req  = run_q && credit_ok && !redirect_valid && !halt_blk;
  assign imem_addr = pc_q;

  assign acc      = imem_req && imem_gnt;
  assign rsp      = imem_rvalid && (outst_q != '0);
  assign dropping = (drop_q != '0);
  assign push     = rsp && !dropping && !redirect_valid;

  assign head     = fifo_q[rd_q];
  assign push_ent = '{ir: imem_rdata, pc: aq_q[ar_q]};

  assign if_valid = (cnt_q != '0);
  assign pop      = if_valid && id_ready && !redirect_valid;
  assign if_ir    = if_valid ? head.ir : shown_q.ir;
  assign if_pc    = if_valid ? head.pc : shown_q.pc;

`ifdef MINI_FETCH_HALT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid)
      halted_d = 1'b0;
    else if (push && imem_rdata[31:26] == 6'b111111)
      halted_d = 1'b1;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  assign halt_blk = halted_q;
`else
  assign halt_blk = 1'b0;
`endif

  always_comb begin
    run_d   = 1'b1;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    aw_d    = aw_q;
    ar_d    = ar_q;
    outst_d = outst_q + CW'(acc) - CW'(rsp);
    shown_d = if_valid ? head : shown_q;
    if (redirect_valid) begin
      // everything still in flight after this edge belongs to the old stream
      pc_d   = redirect_pc;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      aw_d   = '0;
      ar_d   = '0;
      drop_d = outst_d;
    end else begin
      if (acc) begin
        pc_d = pc_q + ADDR_W'(1);
        aw_d = aw_q + PW'(1);
      end
      if (rsp && dropping) drop_d = drop_q - CW'(1);
      if (push) begin
        wr_d = wr_q + PW'(1);
        ar_d = ar_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      pc_q    <= ADDR_W'(RESET_PC);
      cnt_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      aw_q    <= '0;
      ar_q    <= '0;
      shown_q <= '0;
    end else begin
      run_q   <= run_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      aw_q    <= aw_d;
      ar_q    <= ar_d;
      shown_q <= shown_d;
    end
  end

  // data FIFO and the parallel address-tag queue
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
        aq_q[i]   <= '0;
      end
    end else begin
      if (push) fifo_q[wr_q] <= push_ent;
      if (acc && !redirect_valid) aq_q[aw_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_mini_fetch_unit.sv
// Directed bench for mini_fetch_unit: vector table for streaming/backpressure plus
// hand sequences for redirect, wrap, spurious response, reset and halt option.
module tb_mini_fetch_unit;
  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b1;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          if_valid;
  logic [31:0]   if_ir;
  logic [AW-1:0] if_pc;
  logic          id_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  int compared = 0;
  int mismatched = 0;

  mini_fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(0)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk1 = ~clk1;

  // memory model: fixed latency, in-order responses
  typedef struct { int due; logic [AW-1:0] addr; } pend_t;
  pend_t pend[$];
  int cyc = 0;
  int lat = 1;
  int n_acc = 0;
  bit spur = 1'b0;
  bit halt_mem = 1'b0;

  function automatic logic [31:0] mem_val(logic [AW-1:0] a);
    if (halt_mem && a == AW'(3)) return 32'hFC00_0000;
    return 32'h100 + 32'(a);
  endfunction

  always @(posedge clk1) begin
    pend_t p;
    if (!rst_n) pend.delete();
    else begin
      if (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
      if (imem_req && imem_gnt) begin
        p.due = cyc + lat;
        p.addr = imem_addr;
        pend.push_back(p);
        n_acc++;
      end
    end
    cyc++;
  end

  always @(negedge clk1) begin
    #2;
    if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_val(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    imem_gnt = 1'b1;
    lat = 1;
    halt_mem = 1'b0;
    spur = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // wait (bounded) for if_valid, then expect n consecutive words from 'first'
  task automatic expect_stream(string nm, logic [AW-1:0] first, int n, int bound);
    int w = 0;
    while (!if_valid && w < bound) begin
      step();
      w++;
    end
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] p;
      p = first + AW'(i);
      chk($sformatf("%s[%0d] valid", nm, i), 32'(if_valid), 32'd1);
      chk($sformatf("%s[%0d] pc", nm, i), 32'(if_pc), 32'(p));
      chk($sformatf("%s[%0d] ir", nm, i), if_ir, mem_val(p));
      step();
    end
  endtask

  typedef struct {
    bit            rdy;
    bit            v;
    logic [31:0]   ir;
    logic [AW-1:0] pc;
    bit            req;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl[12];
  int a0;

  initial begin
    // rdy, exp valid, ir, pc, req, addr -- one row per edge after reset release
    tbl[0]  = '{1'b1, 1'b0, 32'h000, 10'd0, 1'b1, 10'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'h000, 10'd0, 1'b1, 10'd1};
    tbl[2]  = '{1'b1, 1'b1, 32'h100, 10'd0, 1'b1, 10'd2};
    tbl[3]  = '{1'b1, 1'b1, 32'h101, 10'd1, 1'b1, 10'd3};
    tbl[4]  = '{1'b1, 1'b1, 32'h102, 10'd2, 1'b1, 10'd4};
    tbl[5]  = '{1'b0, 1'b1, 32'h102, 10'd2, 1'b1, 10'd5};
    tbl[6]  = '{1'b0, 1'b1, 32'h102, 10'd2, 1'b0, 10'd6};
    tbl[7]  = '{1'b0, 1'b1, 32'h102, 10'd2, 1'b0, 10'd6};
    tbl[8]  = '{1'b1, 1'b1, 32'h103, 10'd3, 1'b1, 10'd6};
    tbl[9]  = '{1'b1, 1'b1, 32'h104, 10'd4, 1'b1, 10'd7};
    tbl[10] = '{1'b1, 1'b1, 32'h105, 10'd5, 1'b1, 10'd8};
    tbl[11] = '{1'b1, 1'b1, 32'h106, 10'd6, 1'b1, 10'd9};

    step();
    step();
    chk("reset req", 32'(imem_req), 32'd0);
    chk("reset valid", 32'(if_valid), 32'd0);
    chk("reset ir", if_ir, 32'd0);
    chk("reset pc", 32'(if_pc), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      id_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d valid", i), 32'(if_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d ir", i), if_ir, tbl[i].ir);
      chk($sformatf("vec%0d pc", i), 32'(if_pc), 32'(tbl[i].pc));
      chk($sformatf("vec%0d req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d addr", i), 32'(imem_addr), 32'(tbl[i].addr));
    end

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("midrst valid", 32'(if_valid), 32'd0);
    chk("midrst ir", if_ir, 32'd0);
    chk("midrst pc", 32'(if_pc), 32'd0);
    chk("midrst req", 32'(imem_req), 32'd0);

    // backpressure: credit caps accepts at DEPTH
    do_reset();
    a0 = n_acc;
    repeat (10) step();
    chk("stall accepts", 32'(n_acc - a0), 32'd4);
    chk("stall req", 32'(imem_req), 32'd0);
    chk("stall valid", 32'(if_valid), 32'd1);
    chk("stall head pc", 32'(if_pc), 32'd0);
    id_ready = 1'b1;
    expect_stream("drain", 10'd0, 6, 2);

    // redirect with three requests outstanding under 3-cycle latency
    do_reset();
    lat = 3;
    id_ready = 1'b1;
    repeat (4) step();
    chk("lat3 outstanding valid", 32'(if_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 10'h200;
    #1;
    chk("redir cycle req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    expect_stream("redir200", 10'h200, 4, 20);

    // address wrap 1022 -> 1
    do_reset();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'd1022;
    step();
    redirect_valid = 1'b0;
    expect_stream("wrap", 10'd1022, 4, 10);

    // redirect, response and pop all in one cycle
    do_reset();
    id_ready = 1'b1;
    repeat (5) step();
    chk("same pre valid", 32'(if_valid), 32'd1);
    chk("same pre pc", 32'(if_pc), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 10'h055;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("same post valid", 32'(if_valid), 32'd0);
    chk("same post req", 32'(imem_req), 32'd1);
    chk("same post addr", 32'(imem_addr), 32'h055);
    expect_stream("same", 10'h055, 2, 10);

    // response with nothing outstanding is ignored
    do_reset();
    imem_gnt = 1'b0;
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    chk("spur valid", 32'(if_valid), 32'd0);
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    expect_stream("spur", 10'd0, 3, 10);

    // HALT opcode at word 3
    do_reset();
    halt_mem = 1'b1;
    id_ready = 1'b1;
    a0 = n_acc;
    expect_stream("halt", 10'd0, 4, 10);
    repeat (4) step();
`ifdef MINI_FETCH_HALT_EN
    chk("halt req", 32'(imem_req), 32'd0);
    chk("halt accepts", 32'(n_acc - a0), 32'd5);
    redirect_valid = 1'b1;
    redirect_pc = 10'h010;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("unhalt req", 32'(imem_req), 32'd1);
    chk("unhalt addr", 32'(imem_addr), 32'h010);
    expect_stream("unhalt", 10'h010, 2, 10);
`else
    chk("nohalt req", 32'(imem_req), 32'd1);
    chk("nohalt accepts", 32'(n_acc - a0), 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
